popcount_sequencer: RTL and testbench

Sequencing controller that computes the population count of a DATA_W-bit word by streaming it, 4 bits per cycle, through one internal `counting_signals` instance (the 4-input, 3-bit-count datapath). It accumulates the per-nibble counts and returns the total over a valid/ready handshake. It sits between a word producer and a result consumer wherever a wide popcount is needed and area matters more than latency.

---
 rtl/popcount_sequencer.sv | 92 +++++++++
 tb/tb_popcount_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_sequencer.sv
// Wide-word popcount sequencer: streams a word through a 4-bit counter one nibble per cycle,
// accumulates the total and returns it over a valid/ready handshake.

module counting_signals (
   input  logic       a,
   input  logic       b,
   input  logic       c,
   input  logic       d,
   output logic [2:0] count
);
   assign count = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
endmodule

module popcount_sequencer #(
   parameter  int unsigned DATA_W = 32,
   localparam int unsigned CNT_W  = $clog2(DATA_W + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  out_count,
   output logic              busy
);
   localparam int unsigned N     = DATA_W / 4;
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e              r_state;
   state_e              w_state_nxt;
   logic [DATA_W-1:0]   r_shift;
   logic [IDX_W-1:0]    r_idx;
   logic [CNT_W-1:0]    r_acc;
   logic [2:0]          w_count;
   logic                w_accept;
   logic                w_last;

   counting_signals u_count (
      .a     (r_shift[0]),
      .b     (r_shift[1]),
      .c     (r_shift[2]),
      .d     (r_shift[3]),
      .count (w_count)
   );

   // DONE overlaps the next acceptance when the consumer takes the result this cycle.
   assign in_ready  = (r_state == StIdle) || ((r_state == StDone) && out_ready);
   assign w_accept  = in_valid && in_ready;
   assign w_last    = (r_idx == IDX_W'(N - 1));
   assign out_valid = (r_state == StDone);
   assign out_count = r_acc;
   assign busy      = (r_state != StIdle);

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (w_accept) w_state_nxt = StRun;
         StRun:   if (w_last) w_state_nxt = StDone;
         StDone:  if (out_ready) w_state_nxt = w_accept ? StRun : StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift <= '0;
         r_idx   <= '0;
         r_acc   <= '0;
      end else if (w_accept) begin
         r_shift <= in_data;
         r_idx   <= '0;
         r_acc   <= '0;
      end else if (r_state == StRun) begin
         r_shift <= r_shift >> 4;
         r_idx   <= r_idx + 1'b1;
         r_acc   <= r_acc + CNT_W'(w_count);
      end
   end

endmodule

// File: tb/tb_popcount_sequencer.sv
// Self-checking bench for popcount_sequencer: a cycle-level transaction model checked every
// cycle, plus directed words with hand-computed counts and latencies.

module tb_popcount_sequencer;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned N      = DATA_W / 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  out_count;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   popcount_sequencer #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_count (out_count),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int popcnt(input logic [31:0] w);
      int n = 0;
      for (int i = 0; i < 32; i++) n += int'(w[i]);
      return n;
   endfunction

   // Transaction model: a word accepted on an edge produces its result N edges later,
   // held until the consumer handshake.
   bit m_live  = 1'b0;
   bit m_busy  = 1'b0;
   bit m_valid = 1'b0;
   int m_left  = 0;
   int m_res   = 0;

   always @(posedge clk) begin
      bit rdy;
      bit acc;
      if (rst) begin
         m_live  = 1'b1;
         m_busy  = 1'b0;
         m_valid = 1'b0;
         m_left  = 0;
      end else if (m_live) begin
         rdy = !m_busy || (m_valid && out_ready);
         acc = in_valid && rdy;
         if (m_valid && out_ready) begin
            m_valid = 1'b0;
            m_busy  = 1'b0;
         end else if (m_busy && !m_valid) begin
            m_left--;
            if (m_left == 0) m_valid = 1'b1;
         end
         if (acc) begin
            m_busy  = 1'b1;
            m_valid = 1'b0;
            m_left  = N;
            m_res   = popcnt(in_data);
         end
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("mdl_in_ready", 32'(in_ready), 32'(!m_busy || (m_valid && out_ready)));
         chk("mdl_out_valid", 32'(out_valid), 32'(m_valid));
         chk("mdl_busy", 32'(busy), 32'(m_busy));
         if (m_valid) chk("mdl_out_count", 32'(out_count), 32'(m_res));
      end
   end

   // Called mid-cycle just after an acceptance edge; counts edges until out_valid.
   task automatic wait_result(input string name, input int exp_cnt, input int exp_lat);
      int lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 30) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({name, "_count"}, 32'(out_count), 32'(exp_cnt));
   endtask

   task automatic accept_word(input logic [31:0] w);
      int n = 0;
      in_valid = 1'b1;
      in_data  = w;
      @(negedge clk);
      while (!in_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = $urandom;
   endtask

   task automatic check_reset_vals(input string name);
      chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({name, "_out_count"}, 32'(out_count), 32'd0);
      chk({name, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_vals("reset");

      // Idle with in_valid low holds everything.
      repeat (3) @(negedge clk);
      check_reset_vals("idle_hold");
      @(posedge clk);
      #1;

      // All-zero word, then return to idle one cycle after the result.
      accept_word(32'h0000_0000);
      wait_result("zero", 0, 8);
      @(negedge clk);
      chk("zero_in_ready_after", 32'(in_ready), 32'd1);
      chk("zero_busy_after", 32'(busy), 32'd0);
      @(posedge clk);
      #1;

      accept_word(32'hFFFF_FFFF);
      wait_result("ones", 32, 8);
      @(posedge clk);
      #1;

      accept_word(32'hA5A5_0F01);
      wait_result("mixed", 13, 8);
      @(posedge clk);
      #1;

      // Backpressure: result must hold for 5 cycles while the consumer stalls.
      out_ready = 1'b0;
      accept_word(32'h0000_00FF);
      wait_result("bp", 8, 8);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         chk("bp_hold_count", 32'(out_count), 32'd8);
         chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      end
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_released", 32'(out_valid), 32'd0);

      // Back-to-back: second word is taken on the first result's cycle.
      in_valid = 1'b1;
      in_data  = 32'h0000_0001;
      @(posedge clk);
      #1;
      in_data = 32'h0000_0003;
      wait_result("b2b_first", 1, 8);
      chk("b2b_overlap_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_result("b2b_second", 2, 8);
      @(posedge clk);
      #1;

      // Reset while the nibble index is 3.
      in_valid = 1'b1;
      in_data  = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_vals("midrun_rst");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("midrun_no_valid", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      accept_word(32'h0000_0007);
      wait_result("after_rst", 3, 8);
      @(posedge clk);
      #1;
      repeat (2) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end
endmodule
